vga_fb_arbiter: RTL and testbench

- Shares one single-port synchronous frame-buffer RAM between the VGA display read path and a host pixel-write port, in the vga_clk domain.
- The display path is derived from the timing generator's rgb_valid/pix_x/pix_y and always has priority.
- Host writes are buffered in a small FIFO and drained into free memory cycles, mainly blanking.

---
 rtl/vga_fb_arbiter_if.sv | 53 +++++
 rtl/vga_fb_arbiter.sv | 122 ++++++++++++
 tb/tb_vga_fb_arbiter.sv | 231 +++++++++++++++++++++++
 3 files changed

// File: rtl/vga_fb_arbiter_if.sv
// rtl/vga_fb_arbiter_if.sv - display, host-write and RAM signal bundle for vga_fb_arbiter
// VGA_FB_DOUBLE_BUF_EN adds vsync_in/swap_req/disp_bank and widens mem_addr by one bank bit.
interface vga_fb_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 12,
  parameter int LVL_W  = 3
);
`ifdef VGA_FB_DOUBLE_BUF_EN
  localparam int MEM_AW = ADDR_W + 1;
`else
  localparam int MEM_AW = ADDR_W;
`endif

  logic              disp_rd_en;
  logic [ADDR_W-1:0] disp_addr;
  logic [DATA_W-1:0] disp_data;
  logic              disp_data_vld;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic [LVL_W-1:0]  fifo_level;
  logic              mem_en;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
`ifdef VGA_FB_DOUBLE_BUF_EN
  logic              vsync_in;
  logic              swap_req;
  logic              disp_bank;
`endif

  modport master (
`ifdef VGA_FB_DOUBLE_BUF_EN
    output vsync_in, swap_req,
    input  disp_bank,
`endif
    output disp_rd_en, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    input  disp_data, disp_data_vld, wr_ready, fifo_level,
           mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
`ifdef VGA_FB_DOUBLE_BUF_EN
    input  vsync_in, swap_req,
    output disp_bank,
`endif
    input  disp_rd_en, disp_addr, wr_valid, wr_addr, wr_data, mem_rdata,
    output disp_data, disp_data_vld, wr_ready, fifo_level,
           mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - single-port frame-buffer arbiter: display reads first, host writes drained from a FIFO
// Optional VGA_FB_DOUBLE_BUF_EN: bank bit on mem_addr, swapped on vsync rising edge after swap_req.
module vga_fb_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 12,
  parameter int FIFO_DEPTH = 4,
  parameter int LVL_W      = 3
) (
  input  logic            vga_clk,
  input  logic            sys_rst_n,
  vga_fb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
`ifdef VGA_FB_DOUBLE_BUF_EN
  localparam int MEM_AW = ADDR_W + 1;
`else
  localparam int MEM_AW = ADDR_W;
`endif
  localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(FIFO_DEPTH);

  logic [ADDR_W-1:0] fifo_addr_q [FIFO_DEPTH];
  logic [DATA_W-1:0] fifo_data_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              wr_ready_q;
  logic              mem_en_q, mem_we_q;
  logic [MEM_AW-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic              rd_pipe_q, vld_q;
  logic              push, pop;
  logic [MEM_AW-1:0] rd_full_addr, wr_full_addr;

`ifdef VGA_FB_DOUBLE_BUF_EN
  logic vsync_q, pending_q, bank_q;

  assign rd_full_addr  = {bank_q, bus.disp_addr};
  assign wr_full_addr  = {~bank_q, fifo_addr_q[rd_ptr_q]};
  assign bus.disp_bank = bank_q;

  // A swap_req landing on the toggling edge stays pending for the next vsync edge.
  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      vsync_q   <= 1'b0;
      pending_q <= 1'b0;
      bank_q    <= 1'b0;
    end else begin
      vsync_q <= bus.vsync_in;
      if (bus.vsync_in && !vsync_q && pending_q) begin
        bank_q    <= ~bank_q;
        pending_q <= bus.swap_req;
      end else if (bus.swap_req) begin
        pending_q <= 1'b1;
      end
    end
  end
`else
  assign rd_full_addr = bus.disp_addr;
  assign wr_full_addr = fifo_addr_q[rd_ptr_q];
`endif

  always_comb begin
    push    = bus.wr_valid & wr_ready_q;
    pop     = ~bus.disp_rd_en & (level_q != '0);
    level_d = level_q;
    if (push && !pop)
      level_d = level_q + 1'b1;
    else if (pop && !push)
      level_d = level_q - 1'b1;
  end

  always_ff @(posedge vga_clk) begin
    if (push) begin
      fifo_addr_q[wr_ptr_q] <= bus.wr_addr;
      fifo_data_q[wr_ptr_q] <= bus.wr_data;
    end
  end

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      wr_ready_q  <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rd_pipe_q   <= 1'b0;
      vld_q       <= 1'b0;
    end else begin
      level_q    <= level_d;
      wr_ready_q <= (level_d < DEPTH_L);
      rd_pipe_q  <= bus.disp_rd_en;
      vld_q      <= rd_pipe_q;
      if (push)
        wr_ptr_q <= wr_ptr_q + 1'b1;
      if (bus.disp_rd_en) begin
        mem_en_q   <= 1'b1;
        mem_we_q   <= 1'b0;
        mem_addr_q <= rd_full_addr;
      end else if (pop) begin
        mem_en_q    <= 1'b1;
        mem_we_q    <= 1'b1;
        mem_addr_q  <= wr_full_addr;
        mem_wdata_q <= fifo_data_q[rd_ptr_q];
        rd_ptr_q    <= rd_ptr_q + 1'b1;
      end else begin
        mem_en_q <= 1'b0;
        mem_we_q <= 1'b0;
      end
    end
  end

  assign bus.wr_ready      = wr_ready_q;
  assign bus.fifo_level    = level_q;
  assign bus.mem_en        = mem_en_q;
  assign bus.mem_we        = mem_we_q;
  assign bus.mem_addr      = mem_addr_q;
  assign bus.mem_wdata     = mem_wdata_q;
  assign bus.disp_data     = bus.mem_rdata;
  assign bus.disp_data_vld = vld_q;
endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
// Also exercises bank swapping when built with VGA_FB_DOUBLE_BUF_EN.
module tb_vga_fb_arbiter;
  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 12;
  localparam int FIFO_DEPTH = 4;
  localparam int LVL_W      = 3;
`ifdef VGA_FB_DOUBLE_BUF_EN
  localparam logic [31:0] WR_MSB = 32'd1 << ADDR_W;
  localparam logic [31:0] RD_MSB = 32'd1 << ADDR_W;
`else
  localparam logic [31:0] WR_MSB = 32'd0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LVL_W(LVL_W)) bus ();

  vga_fb_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .LVL_W(LVL_W)
  ) dut (
    .vga_clk  (clk),
    .sys_rst_n(rst_n),
    .bus      (bus.slave)
  );

  // RAM stand-in: read data is the low 12 address bits, one cycle after a read.
  always @(posedge clk)
    if (bus.mem_en && !bus.mem_we)
      bus.mem_rdata <= bus.mem_addr[11:0];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [ADDR_W-1:0] wa [6];
  logic [DATA_W-1:0] wd [6];
  int vld_cnt, data_err, we_cnt, k;
  logic acc;
  logic [DATA_W-1:0] exp_d;

  initial begin
    bus.disp_rd_en = 1'b0;
    bus.disp_addr  = '0;
    bus.wr_valid   = 1'b0;
    bus.wr_addr    = '0;
    bus.wr_data    = '0;
    bus.mem_rdata  = '0;
`ifdef VGA_FB_DOUBLE_BUF_EN
    bus.vsync_in   = 1'b0;
    bus.swap_req   = 1'b0;
`endif
    for (int j = 0; j < 6; j++) begin
      wa[j] = ADDR_W'(32'h200 + j);
      wd[j] = DATA_W'(32'hA00 + j);
    end

    // Reset state
    repeat (3) tick();
    chk("rst_mem_en", 32'(bus.mem_en), 0);
    chk("rst_mem_we", 32'(bus.mem_we), 0);
    chk("rst_mem_addr", 32'(bus.mem_addr), 0);
    chk("rst_mem_wdata", 32'(bus.mem_wdata), 0);
    chk("rst_level", 32'(bus.fifo_level), 0);
    chk("rst_vld", 32'(bus.disp_data_vld), 0);
    rst_n = 1'b1;
    #1;
    chk("rdy_before_edge", 32'(bus.wr_ready), 0);
    tick();
    chk("rdy_after_edge", 32'(bus.wr_ready), 1);

    // Single write, idle display
    bus.wr_valid = 1'b1;
    bus.wr_addr  = ADDR_W'(32'h10);
    bus.wr_data  = 12'hF00;
    tick();
    bus.wr_valid = 1'b0;
    chk("wr1_level", 32'(bus.fifo_level), 1);
    chk("wr1_en_early", 32'(bus.mem_en), 0);
    tick();
    chk("wr1_en", 32'(bus.mem_en), 1);
    chk("wr1_we", 32'(bus.mem_we), 1);
    chk("wr1_addr", 32'(bus.mem_addr), 32'h10 | WR_MSB);
    chk("wr1_wdata", 32'(bus.mem_wdata), 32'hF00);
    chk("wr1_level0", 32'(bus.fifo_level), 0);
    tick();
    chk("idle_en", 32'(bus.mem_en), 0);
    chk("idle_addr_hold", 32'(bus.mem_addr), 32'h10 | WR_MSB);

    // 640 back-to-back display reads
    vld_cnt = 0; data_err = 0; we_cnt = 0;
    for (int i = 0; i < 642; i++) begin
      bus.disp_rd_en = (i < 640);
      bus.disp_addr  = ADDR_W'(i);
      tick();
      if (i == 0) begin
        chk("rd_first_vld", 32'(bus.disp_data_vld), 0);
        chk("rd_first_en", 32'(bus.mem_en), 1);
        chk("rd_first_addr", 32'(bus.mem_addr), 0);
      end
      if (i == 1)
        chk("rd_lat2_vld", 32'(bus.disp_data_vld), 1);
      if (bus.mem_we) we_cnt++;
      if (bus.disp_data_vld) begin
        vld_cnt++;
        exp_d = DATA_W'(i - 1);
        if (bus.disp_data !== exp_d) data_err++;
      end
    end
    chk("rd_vld_count", 32'(vld_cnt), 640);
    chk("rd_data_errors", 32'(data_err), 0);
    chk("rd_no_writes", 32'(we_cnt), 0);

    // Six writes offered against continuous reads
    k = 0; we_cnt = 0;
    bus.disp_rd_en = 1'b1;
    bus.disp_addr  = ADDR_W'(32'h100);
    for (int c = 0; c < 8; c++) begin
      bus.wr_valid = (k < 6);
      if (k < 6) begin bus.wr_addr = wa[k]; bus.wr_data = wd[k]; end
      acc = bus.wr_valid && bus.wr_ready;
      tick();
      if (acc) k++;
      if (bus.mem_we) we_cnt++;
    end
    chk("full_accepted", 32'(k), 4);
    chk("full_level", 32'(bus.fifo_level), 4);
    chk("full_ready", 32'(bus.wr_ready), 0);
    chk("full_no_writes", 32'(we_cnt), 0);
    bus.disp_rd_en = 1'b0;
    for (int j = 0; j < 6; j++) begin
      bus.wr_valid = (k < 6);
      if (k < 6) begin bus.wr_addr = wa[k]; bus.wr_data = wd[k]; end
      acc = bus.wr_valid && bus.wr_ready;
      tick();
      if (acc) k++;
      chk($sformatf("drain%0d_we", j), 32'(bus.mem_we), 1);
      chk($sformatf("drain%0d_addr", j), 32'(bus.mem_addr), 32'(wa[j]) | WR_MSB);
      chk($sformatf("drain%0d_wdata", j), 32'(bus.mem_wdata), 32'(wd[j]));
    end
    bus.wr_valid = 1'b0;
    tick();
    chk("drain_accepted", 32'(k), 6);
    chk("drain_we_off", 32'(bus.mem_we), 0);
    chk("drain_level", 32'(bus.fifo_level), 0);

    // Reset with queued writes and reads in flight
    bus.disp_rd_en = 1'b1;
    bus.disp_addr  = ADDR_W'(32'h20);
    for (int c = 0; c < 3; c++) begin
      bus.wr_valid = 1'b1;
      bus.wr_addr  = ADDR_W'(32'h300 + c);
      bus.wr_data  = DATA_W'(32'h5A0 + c);
      tick();
    end
    bus.wr_valid = 1'b0;
    chk("pre_rst_level", 32'(bus.fifo_level), 3);
    chk("pre_rst_vld", 32'(bus.disp_data_vld), 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_vld", 32'(bus.disp_data_vld), 0);
    chk("mid_rst_level", 32'(bus.fifo_level), 0);
    chk("mid_rst_en", 32'(bus.mem_en), 0);
    bus.disp_rd_en = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    we_cnt = 0;
    repeat (6) begin
      tick();
      if (bus.mem_we) we_cnt++;
    end
    chk("post_rst_no_writes", 32'(we_cnt), 0);
    chk("post_rst_level", 32'(bus.fifo_level), 0);
    chk("post_rst_ready", 32'(bus.wr_ready), 1);

`ifdef VGA_FB_DOUBLE_BUF_EN
    bus.swap_req = 1'b1;
    tick();
    bus.swap_req = 1'b0;
    tick();
    chk("db_bank_before", 32'(bus.disp_bank), 0);
    bus.vsync_in = 1'b1;
    tick();
    chk("db_bank_toggle", 32'(bus.disp_bank), 1);
    bus.disp_rd_en = 1'b1;
    bus.disp_addr  = ADDR_W'(5);
    tick();
    bus.disp_rd_en = 1'b0;
    chk("db_read_addr", 32'(bus.mem_addr), RD_MSB | 32'd5);
    bus.wr_valid = 1'b1;
    bus.wr_addr  = ADDR_W'(6);
    bus.wr_data  = 12'h123;
    tick();
    bus.wr_valid = 1'b0;
    tick();
    chk("db_write_we", 32'(bus.mem_we), 1);
    chk("db_write_addr", 32'(bus.mem_addr), 32'd6);
    bus.vsync_in = 1'b0;
    tick();
    bus.vsync_in = 1'b1;
    tick();
    tick();
    chk("db_no_second_toggle", 32'(bus.disp_bank), 1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
